// File: rtl/implication_sweep_checker_pkg.sv
// Shared state encoding and reference truth table for the implication sweep checker.
package guia05_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int NUM_VEC = 4;

  // Expected a -> b output, indexed by {a,b}.
  localparam logic [NUM_VEC-1:0] EXP_TT = 4'b1011;

endpackage

// File: rtl/implication_sweep_checker_if.sv
// Control, stimulus and result signals between the sweep checker and its user/gate.
interface implication_sweep_checker_if;
  logic       start;
  logic       abort;
  logic       dut_s;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;
  logic [3:0] obs_vec;

  modport master (
    output start, abort, dut_s,
    input  drv_a, drv_b, busy, done, pass, err_cnt, fail_mask, obs_vec
  );

  modport slave (
    input  start, abort, dut_s,
    output drv_a, drv_b, busy, done, pass, err_cnt, fail_mask, obs_vec
  );
endinterface

// File: rtl/implication_sweep_checker_settle_ctr.sv
// Settle down-counter: load restarts the hold period, expire flags its final cycle.
module sweep_settle_ctr #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [3:0] cnt;

  // Loading SETTLE-1 makes the hold last SETTLE cycles including the terminal one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= 4'(SETTLE - 1);
    else if (en && cnt != '0)    cnt <= cnt - 4'd1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/implication_sweep_checker.sv
// Sweeps all four {a,b} vectors into an implication gate and scores its output.
// Build option: IMPL_SWEEP_CAPTURE_EN adds the per-vector obs_vec capture register.
import guia05_pkg::*;

module implication_sweep_checker #(
  parameter int SETTLE = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  implication_sweep_checker_if.slave   bus
);

  // state  | meaning
  // IDLE   | waiting for start, results held
  // DRIVE  | vector idx applied, settle counter running
  // SAMPLE | dut_s compared against expected for idx
  // DONE   | done pulse, pass loaded

  sweep_state_t state, state_nx;
  logic [1:0]   idx, idx_nx;
  logic         ctr_load, ctr_en, ctr_expire;
  logic         do_sample, accept, abort_hit, in_vec_nx, mismatch;

  sweep_settle_ctr #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ctr_load),
    .en     (ctr_en),
    .expire (ctr_expire)
  );

  assign accept    = (state == IDLE) && bus.start && !bus.abort;
  assign abort_hit = bus.abort && ((state == DRIVE) || (state == SAMPLE));
  assign mismatch  = (bus.dut_s != EXP_TT[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    do_sample = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = DRIVE;
          idx_nx   = '0;
          ctr_load = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.abort)       state_nx = IDLE;
        else if (ctr_expire) state_nx = SAMPLE;
        else                 ctr_en   = 1'b1;
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else begin
          do_sample = 1'b1;
          if (idx == 2'(NUM_VEC - 1)) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 2'd1;
            state_nx = DRIVE;
            ctr_load = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_vec_nx = (state_nx == DRIVE) || (state_nx == SAMPLE);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

  // Stimulus is registered from next-state so the gate sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.drv_a     <= 1'b0;
      bus.drv_b     <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_cnt   <= '0;
      bus.fail_mask <= '0;
    end else begin
      bus.drv_a <= in_vec_nx & idx_nx[1];
      bus.drv_b <= in_vec_nx & idx_nx[0];
      if (accept) begin
        bus.pass      <= 1'b0;
        bus.err_cnt   <= '0;
        bus.fail_mask <= '0;
      end else if (abort_hit) begin
        bus.pass <= 1'b0;
      end else if (do_sample && mismatch) begin
        bus.fail_mask[idx] <= 1'b1;
        if (bus.err_cnt < 3'(NUM_VEC)) bus.err_cnt <= bus.err_cnt + 3'd1;
      end else if (state == DONE) begin
        bus.pass <= (bus.err_cnt == '0);
      end
    end
  end

`ifdef IMPL_SWEEP_CAPTURE_EN
  logic [3:0] obs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         obs_q      <= '0;
    else if (accept)    obs_q      <= '0;
    else if (do_sample) obs_q[idx] <= bus.dut_s;
  end

  assign bus.obs_vec = obs_q;
`else
  assign bus.obs_vec = 4'b0000;
`endif

endmodule
